serial_parallel: RTL and testbench
==================================

Name: serial_parallel

Overview:
Receive end of the 8b parallel/serial link. Recovers byte alignment from a 1-bit stream sent MSB-first, one bit per clk. Alignment uses the comma symbol 0xBC, which the transmitter sends while idle. After ACTIVE_CNT consecutive aligned commas the link is declared active. From then on, every non-comma byte is presented on data_out_8b with valid_out asserted. Sits directly after the parallel-to-serial transmitter, on the same clk, in the loopback path.

Parameters:
COMMA, 8'hBC, alignment/idle symbol
ACTIVE_CNT, 4, consecutive aligned commas required to assert active (range 1..15)

Ports:
clk  input  1  link bit clock; one serial bit sampled per rising edge
reset  input  1  asynchronous, active-low reset
data_in_serial  input  1  serial bit stream, MSB of each byte first
data_out_8b  output  8  recovered data byte
valid_out  output  1  data_out_8b holds a data (non-comma) byte for the current byte period
active  output  1  link aligned and active

Behaviour:
- Reset (reset=0, asynchronous):
  - sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH.
  - data_out_8b=8'h00, valid_out=0, active=0.
  - Takes effect mid-byte with no waiting; after release, alignment restarts from SEARCH.
- Shifting: sr <= {sr[6:0], data_in_serial} every clk, in all states. Define win = {sr[6:0], data_in_serial}, the byte ending with the current bit.
- State SEARCH (bit-by-bit hunt):
  - Each clk, if win==COMMA: go to LOCKED, bit_cnt<=0, bc_cnt<=1.
  - If ACTIVE_CNT==1, go straight to ACTIVE and set active<=1 on that same edge.
  - Otherwise stay in SEARCH; outputs unchanged.
- bit_cnt (LOCKED/ACTIVE):
  - Increments 0..7 and wraps; the byte boundary is the clk where bit_cnt==7.
  - Evaluated only at boundaries, using win.
- State LOCKED:
  - At a boundary with win==COMMA: bc_cnt++. When the incremented value equals ACTIVE_CNT, go to ACTIVE and set active<=1 on that edge.
  - At a boundary with win!=COMMA: go to SEARCH, bc_cnt<=0. This is the false-lock recovery path.
  - valid_out stays 0 throughout.
- State ACTIVE, evaluated at each boundary:
  - win!=COMMA: data_out_8b<=win, valid_out<=1.
  - win==COMMA: valid_out<=0, data_out_8b holds its previous value.
  - Outputs are registered. The byte appears on the edge that samples its last bit, i.e. visible in the cycle after that bit is presented.
  - valid_out and data_out_8b are stable for the full 8-clk byte period until the next boundary.
- Sticky lock: active, once set, stays 1 until reset. No loss-of-lock detection in ACTIVE.
- Widths: bc_cnt is 4 bits and saturates at ACTIVE_CNT. bit_cnt is 3 bits and wraps naturally.
- Nominal lock time: an aligned comma stream from the first comma bit gives active=1 after exactly 8*ACTIVE_CNT clks.
- Misaligned start: leading junk bits delay lock by the junk length only.

Test Plan:
- Aligned idle: after reset release, send 0xBC ×4 MSB-first -> active rises on the 32nd bit edge; valid_out=0 and data_out_8b=0x00 throughout.
- Data after lock: 0xBC×4, then 0xAA, 0xAB -> data_out_8b=0xAA with valid_out=1 for 8 clks starting at bit 40, then data_out_8b=0xAB at bit 48.
- Return to idle: 0xBC×4, 0xAA, 0xBC -> at bit 48 valid_out=0 and data_out_8b holds 0xAA; active remains 1.
- Misalignment: bits 1,0,1 then 0xBC×4 -> lock found at bit 11, active=1 at bit 35; no valid_out pulses before that.
- Broken comma run: 0xBC, 0xBC, 0x23, 0xBC×4 -> return to SEARCH at the 0x23 boundary (bit 24); active only at bit 56; valid_out never set for 0x23.
- Reset mid-byte: in ACTIVE after 0xAA, drive reset=0 at bit 3 of the next byte -> all outputs clear immediately; after release a fresh 0xBC×4 is needed before active=1.

Source files
------------

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver for the 8b loopback link.
//
// Recovers byte alignment from an MSB-first serial stream (one bit per clk)
// by hunting for the comma symbol. Once ACTIVE_CNT consecutive commas land on
// the recovered byte boundary, the link is declared active, and every non-comma
// byte is presented on data_out_8b with valid_out high for one byte period.
//
// Ports:
//   clk            link bit clock; one serial bit sampled per rising edge
//   reset          asynchronous, active-low reset
//   data_in_serial serial bit stream, MSB of each byte first
//   data_out_8b    recovered data byte (registered)
//   valid_out      data_out_8b holds a data byte for the current byte period
//   active         link aligned and active (sticky until reset)
module serial_parallel #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned ACTIVE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in_serial,
    output logic [7:0] data_out_8b,
    output logic       valid_out,
    output logic       active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BIT_W  = 3;

    localparam logic [CNT_W-1:0] ACTIVE_CNT_L = CNT_W'(ACTIVE_CNT);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(BYTE_W - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t             state;
    // Only the 7 most recent bits need storing; the 8th bit of the window is
    // the bit on the wire this cycle.
    logic [BYTE_W-2:0]  sr;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bc_cnt;

    logic [BYTE_W-1:0]  win_c;
    logic               is_comma_c;
    logic               boundary_c;
    logic [CNT_W-1:0]   bc_inc_c;

    // Byte ending with the current bit, and the decodes taken from it.
    always_comb begin
        win_c      = {sr, data_in_serial};
        is_comma_c = (win_c == COMMA);
        boundary_c = (bit_cnt == LAST_BIT);
        // Saturate at ACTIVE_CNT so the count never wraps.
        bc_inc_c   = (bc_cnt < ACTIVE_CNT_L) ? (bc_cnt + CNT_W'(1)) : bc_cnt;
    end

    // Alignment FSM, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            bc_cnt      <= '0;
            data_out_8b <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr <= win_c[BYTE_W-2:0];

            case (state)
                // Bit-by-bit hunt: any position may start a byte.
                ST_SEARCH: begin
                    bit_cnt <= '0;
                    if (is_comma_c) begin
                        bc_cnt <= CNT_W'(1);
                        if (ACTIVE_CNT_L == CNT_W'(1)) begin
                            state  <= ST_ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                end

                // Tentative alignment: every boundary must carry a comma,
                // otherwise the lock was false and the hunt restarts.
                ST_LOCKED: begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (boundary_c) begin
                        if (is_comma_c) begin
                            bc_cnt <= bc_inc_c;
                            if (bc_inc_c == ACTIVE_CNT_L) begin
                                state  <= ST_ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= ST_SEARCH;
                            bc_cnt  <= '0;
                            bit_cnt <= '0;
                        end
                    end
                end

                // Aligned: publish data bytes, suppress idle commas. Lock is
                // sticky; no loss-of-lock detection here.
                ST_ACTIVE: begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (boundary_c) begin
                        if (is_comma_c) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out_8b <= win_c;
                            valid_out   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= ST_SEARCH;
                    bit_cnt <= '0;
                    bc_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parallel.sv
// Testbench for serial_parallel: directed link scenarios plus randomized
// streams, every bit checked against a behavioural model built on the full
// bit history since the last reset.
module tb_serial_parallel;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         ACT_N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in_serial;
    logic [7:0] data_out_8b;
    logic       valid_out;
    logic       active;

    int n_cmp = 0;
    int n_err = 0;

    serial_parallel #(
        .COMMA      (COMMA),
        .ACTIVE_CNT (ACT_N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_serial (data_in_serial),
        .data_out_8b    (data_out_8b),
        .valid_out      (valid_out),
        .active         (active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: bits since reset, lock position, comma run length.
    bit         hist[$];
    bit         m_locked;
    bit         m_act;
    bit         m_vld;
    int         m_lock_pos;
    int         m_run;
    logic [7:0] m_dout;

    task automatic model_reset();
        hist.delete();
        m_locked   = 1'b0;
        m_act      = 1'b0;
        m_vld      = 1'b0;
        m_lock_pos = 0;
        m_run      = 0;
        m_dout     = 8'h00;
    endtask

    // Last 8 received bits, oldest in the MSB; bits before reset read as 0.
    function automatic logic [7:0] last_byte();
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = hist.size() - 8 + k;
            if (idx >= 0) w[7-k] = hist[idx];
        end
        return w;
    endfunction

    task automatic model_step(input bit b);
        logic [7:0] w;
        int n;
        hist.push_back(b);
        n = hist.size();
        w = last_byte();
        if (!m_locked) begin
            if (w == COMMA) begin
                m_locked   = 1'b1;
                m_lock_pos = n;
                m_run      = 1;
                if (m_run == ACT_N) m_act = 1'b1;
            end
        end else if (((n - m_lock_pos) % 8) == 0) begin
            if (m_act) begin
                if (w != COMMA) begin
                    m_dout = w;
                    m_vld  = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end else if (w == COMMA) begin
                m_run++;
                if (m_run == ACT_N) m_act = 1'b1;
            end else begin
                m_locked = 1'b0;
                m_run    = 0;
            end
        end
    endtask

    task automatic send_bit(input bit b);
        data_in_serial = b;
        @(posedge clk);
        #1;
        model_step(b);
        check_eq($sformatf("dout@%0d", hist.size()), 32'(data_out_8b), 32'(m_dout));
        check_eq($sformatf("valid@%0d", hist.size()), 32'(valid_out), 32'(m_vld));
        check_eq($sformatf("active@%0d", hist.size()), 32'(active), 32'(m_act));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_bits(input logic [7:0] v, input int cnt);
        for (int i = 7; i > 7 - cnt; i--) send_bit(v[i]);
    endtask

    // Asynchronous reset applied away from the clock edge; outputs must clear
    // before any further edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check_eq({tag, "_rst_dout"}, 32'(data_out_8b), 32'h0);
        check_eq({tag, "_rst_valid"}, 32'(valid_out), 32'h0);
        check_eq({tag, "_rst_active"}, 32'(active), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        data_in_serial = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("por_dout", 32'(data_out_8b), 32'h0);
        check_eq("por_valid", 32'(valid_out), 32'h0);
        check_eq("por_active", 32'(active), 32'h0);
        reset = 1'b1;

        // Aligned idle: active exactly on the 32nd bit.
        repeat (3) send_byte(COMMA);
        send_bits(COMMA, 7);
        check_eq("idle_active_b31", 32'(active), 32'h0);
        send_bit(1'b0);
        check_eq("idle_active_b32", 32'(active), 32'h1);
        check_eq("idle_valid", 32'(valid_out), 32'h0);
        check_eq("idle_dout", 32'(data_out_8b), 32'h0);

        // Data after lock, with stability across the byte period.
        send_byte(8'hAA);
        check_eq("data_aa", 32'(data_out_8b), 32'hAA);
        check_eq("data_aa_valid", 32'(valid_out), 32'h1);
        send_bits(8'hAB, 7);
        check_eq("data_aa_hold", 32'(data_out_8b), 32'hAA);
        check_eq("data_aa_hold_v", 32'(valid_out), 32'h1);
        send_bit(1'b1);
        check_eq("data_ab", 32'(data_out_8b), 32'hAB);

        // Return to idle.
        do_reset("idle_ret");
        repeat (4) send_byte(COMMA);
        send_byte(8'hAA);
        send_byte(COMMA);
        check_eq("ret_valid", 32'(valid_out), 32'h0);
        check_eq("ret_dout", 32'(data_out_8b), 32'hAA);
        check_eq("ret_active", 32'(active), 32'h1);

        // Reset three bits into the byte after 0xAA.
        do_reset("mid_pre");
        repeat (4) send_byte(COMMA);
        send_byte(8'hAA);
        send_bits(8'h55, 3);
        do_reset("mid");
        repeat (3) send_byte(COMMA);
        check_eq("mid_relock_early", 32'(active), 32'h0);
        send_byte(COMMA);
        check_eq("mid_relock", 32'(active), 32'h1);

        // Misaligned start: three junk bits shift lock to bit 35.
        do_reset("misal");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (3) send_byte(COMMA);
        send_bits(COMMA, 7);
        check_eq("misal_b34", 32'(active), 32'h0);
        send_bit(1'b0);
        check_eq("misal_b35", 32'(active), 32'h1);

        // Broken comma run: false lock dropped, active only at bit 56.
        do_reset("broken");
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h23);
        repeat (3) send_byte(COMMA);
        check_eq("broken_b48", 32'(active), 32'h0);
        send_byte(COMMA);
        check_eq("broken_b56", 32'(active), 32'h1);
        check_eq("broken_valid", 32'(valid_out), 32'h0);

        // Randomized streams: junk, a comma run of random length, then a mix
        // of data and idle bytes.
        for (int t = 0; t < 25; t++) begin
            int junk;
            int ncomma;
            do_reset($sformatf("rnd%0d", t));
            junk   = int'($urandom_range(0, 15));
            ncomma = int'($urandom_range(2, 6));
            for (int j = 0; j < junk; j++) send_bit(1'($urandom));
            for (int c = 0; c < ncomma; c++) send_byte(COMMA);
            for (int d = 0; d < 12; d++) begin
                if ($urandom_range(0, 3) == 0) send_byte(COMMA);
                else send_byte(8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
